apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB initiator. It accepts read and write commands on a valid/ready command port, drives the APB setup and access phases to one of several slaves (e.g. the UART slave at 0x20–0x2F), and waits for `pready`. It returns read data and an error flag on a one-cycle response port. It sits between the on-chip controller and the APB slaves, and covers address decode, wait states, slave errors and hung-slave timeout.

## Interface
Parameters:
- `NUM_SLAVES`, 3 — number of `psel` lines (1–16).
- `TIMEOUT_CYCLES`, 255 — ACCESS wait-cycle limit before abort; 0 disables the timeout.

Ports:
- `pclk` in 1 — the only clock.
- `presetn` in 1 — synchronous, active-low reset.
- `cmd_valid` in 1 — command request.
- `cmd_ready` out 1 — command accepted when high together with `cmd_valid` at a `pclk` edge.
- `cmd_write` in 1 — 1 = write, 0 = read.
- `cmd_addr` in 8 — target address.
- `cmd_wdata` in 8 — write data.
- `rsp_valid` out 1 — one-cycle completion pulse.
- `rsp_rdata` out 8 — read data; 0 for writes and for errors.
- `rsp_err` out 1 — decode error, `pslverr`, or timeout.
- `psel` out NUM_SLAVES — one-hot slave select.
- `penable` out 1 — APB enable.
- `pwrite` out 1 — APB direction.
- `paddr` out 8 — APB address.
- `pwdata` out 8 — APB write data.
- `prdata` in 8 — APB read data; already muxed from the selected slave.
- `pready` in 1 — APB ready; already muxed.
- `pslverr` in 1 — APB error; tie to 0 for slaves that lack it.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - All outputs are registered or decoded directly from the state register.
  - `cmd_ready` is 1 iff in IDLE.
  - `rsp_valid` is 1 iff in RESP.
- **IDLE**
  - On `cmd_valid`, capture `cmd_write`, `cmd_addr` and `cmd_wdata`.
  - Slave index = `cmd_addr[7:4]`.
  - Index < NUM_SLAVES → SETUP.
  - Otherwise → RESP with `rsp_err`=1 and `rsp_rdata`=0. This is a decode error; no APB activity occurs.
- **SETUP**
  - `psel[index]`=1 and `penable`=0.
  - `paddr`, `pwrite` and `pwdata` are driven from the captured values; `pwdata`=0 for reads.
  - Always → ACCESS.
- **ACCESS**
  - `psel[index]`=1 and `penable`=1; `paddr`, `pwrite` and `pwdata` are held stable.
  - `pready`=1 at an edge → RESP. Capture `rsp_rdata` = `prdata` for reads (0 for writes) and `rsp_err` = `pslverr`.
  - `pready`=0 at an edge → increment the wait counter.
  - Counter reaches TIMEOUT_CYCLES (nonzero) → RESP with `rsp_err`=1 and `rsp_rdata`=0.
- **RESP**
  - `psel`=0, `penable`=0, `rsp_valid`=1 for exactly one cycle.
  - Always → IDLE.
- The wait counter is 8 bits. It clears on entry to SETUP and saturates; it never wraps.
- `paddr`, `pwrite` and `pwdata` keep their last values outside transfers.
- `cmd_*` inputs are ignored outside IDLE.
- `pready` is ignored outside ACCESS.

## Timing
- **Reset**
  - With `presetn`=0 at an edge, the FSM goes to IDLE and every output is 0.
  - This includes `cmd_ready`, which stays 0 while `presetn` is low.
  - `cmd_ready`=1 from the first cycle after reset release.
- **Reset mid-transfer**
  - `psel` and `penable` drop after that edge.
  - No `rsp_valid` is issued for the aborted command.
- **Normal transfer**, command accepted at edge T:
  - SETUP in cycle T+1, ACCESS from T+2.
  - With `pready` sampled high at edge T+2+n (n wait cycles), `rsp_valid` is high in cycle T+3+n.
  - `cmd_ready` returns in cycle T+4+n.
- **Throughput**
  - Minimum 4 cycles per APB transfer.
  - Decode error: `rsp_valid` in T+1, `cmd_ready` in T+2.
- **Timeout**
  - With `pready` stuck low, RESP is entered after TIMEOUT_CYCLES ACCESS cycles.
  - `psel` is never high for more than TIMEOUT_CYCLES+1 cycles.
- `pready` and `pslverr` are sampled at the same edge.
- `pslverr` without `pready` is ignored.

## Test plan
- Write 0xA5 to 0x20; slave returns `pready` after 1 wait cycle → `psel`=3'b100 for 3 cycles with `pwrite`=1, `paddr`=0x20, `pwdata`=0xA5. `penable` is high for 2 cycles, then `rsp_valid`=1, `rsp_err`=0, `rsp_rdata`=0x00.
- Read 0x21 with zero-wait slave, `prdata`=0x3C → `rsp_rdata`=0x3C and `rsp_err`=0 in cycle T+3.
- NUM_SLAVES=3, read 0x50 → no `psel` or `penable` activity; `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0 in T+1.
- TIMEOUT_CYCLES=8, `pready` held 0 → `penable` high for exactly 8 cycles, then `rsp_err`=1. A following read of 0x22 with `prdata`=0x02 completes normally with `rsp_rdata`=0x02.
- `cmd_valid` held high with two writes back-to-back (0x20←0x11, 0x20←0x22) → second SETUP begins exactly 4 cycles after the first; no overlap of `psel`.
- Assert `presetn`=0 during ACCESS, release after 2 cycles → all outputs 0, no `rsp_valid`. `cmd_ready`=1 in the first cycle after release, and the next command completes normally.

Source files
------------

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: command port -> SETUP/ACCESS phases -> one-cycle response pulse.
// Latency: response 3+n cycles after accept (n = wait states), 1 cycle on decode error; cmd_ready low while busy.
module apb_master #(
    parameter int NUM_SLAVES     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [7:0]            cmd_addr,
    input  logic [7:0]            cmd_wdata,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_err,
    output logic [NUM_SLAVES-1:0] psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [7:0]            paddr,
    output logic [7:0]            pwdata,
    input  logic [7:0]            prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYCLES);

    state_t                  state_q;
    logic                    cmd_ready_q;
    logic                    rsp_valid_q;
    logic [7:0]              rsp_rdata_q;
    logic                    rsp_err_q;
    logic [NUM_SLAVES-1:0]   psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [7:0]              paddr_q;
    logic [7:0]              pwdata_q;
    logic [7:0]              wait_q;

    logic                    decode_hit;
    logic [NUM_SLAVES-1:0]   psel_d;
    logic [8:0]              wait_inc;
    logic [7:0]              wait_d;

    always_comb begin
        decode_hit = ({1'b0, cmd_addr[7:4]} < 5'(NUM_SLAVES));
        psel_d     = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            psel_d[i] = (cmd_addr[7:4] == 4'(i));
        end
        wait_inc = {1'b0, wait_q} + 9'd1;
        wait_d   = (wait_q == 8'hFF) ? wait_q : wait_inc[7:0];
    end

    // cmd_ready is a register rather than a state decode so it stays low through reset.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 8'h00;
            pwdata_q    <= 8'h00;
            wait_q      <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        if (decode_hit) begin
                            state_q  <= S_SETUP;
                            psel_q   <= psel_d;
                            paddr_q  <= cmd_addr;
                            pwrite_q <= cmd_write;
                            pwdata_q <= cmd_write ? cmd_wdata : 8'h00;
                            wait_q   <= 8'h00;
                        end else begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 8'h00;
                        end
                    end
                end
                S_SETUP: begin
                    state_q   <= S_ACCESS;
                    penable_q <= 1'b1;
                end
                S_ACCESS: begin
                    if (pready) begin
                        state_q     <= S_RESP;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= pslverr;
                        rsp_rdata_q <= (pwrite_q || pslverr) ? 8'h00 : prdata;
                    end else if ((TIMEOUT_CYCLES != 0) && (wait_inc >= TO_LIM)) begin
                        state_q     <= S_RESP;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 8'h00;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 8'h00;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (3 slaves, 8-cycle timeout) with hand-computed expectations.
module tb_apb_master;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [2:0] psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int vectors     = 0;
    int miscompares = 0;

    always #5 pclk = ~pclk;

    apb_master #(
        .NUM_SLAVES    (3),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_rspv"},  32'(rsp_valid), 32'd0);
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
        chk({tag, "_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_psel"},  32'(psel),      32'd0);
        chk({tag, "_pen"},   32'(penable),   32'd0);
        chk({tag, "_apb"},   {15'd0, pwrite, paddr, pwdata}, 32'd0);
    endtask

    // Issues one command and plays the slave: pready rises after 'waits' ACCESS cycles (never if waits < 0).
    task automatic xfer(input string tag, input bit w, input logic [7:0] a, input logic [7:0] d,
                        input int waits, input logic [7:0] rd, input bit serr,
                        input logic [2:0] exp_psel, input int exp_psel_cyc, input int exp_pen_cyc,
                        input int exp_lat, input logic [7:0] exp_rd, input bit exp_err);
        int  psel_cyc = 0;
        int  pen_cyc  = 0;
        int  wcnt     = 0;
        bool_t: begin end
        for (int i = 0; i < 20 && !cmd_ready; i++) tick();
        chk({tag, "_ready_in"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 8'hEE;
        cmd_wdata = 8'hEE;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (psel != 3'b000) begin
                psel_cyc++;
                chk({tag, "_psel"},   32'(psel),   32'(exp_psel));
                chk({tag, "_paddr"},  32'(paddr),  32'(a));
                chk({tag, "_pwrite"}, 32'(pwrite), 32'(w));
                chk({tag, "_pwdata"}, 32'(pwdata), w ? 32'(d) : 32'd0);
            end
            if (penable) pen_cyc++;
            if (penable && waits >= 0 && wcnt == waits) begin
                pready  = 1'b1;
                prdata  = rd;
                pslverr = serr;
            end else begin
                pready  = 1'b0;
                prdata  = 8'h99;
                pslverr = 1'b1;
                if (penable) wcnt++;
            end
            if (rsp_valid) begin
                chk({tag, "_lat"},   32'(cyc),       32'(exp_lat));
                chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
                chk({tag, "_err"},   32'(rsp_err),   32'(exp_err));
                chk({tag, "_rsp_psel"}, {31'd0, (psel != 3'b000) || penable}, 32'd0);
                break;
            end
            if (cyc == 300) chk({tag, "_no_rsp"}, 32'd0, 32'd1);
            tick();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        chk({tag, "_psel_cyc"}, 32'(psel_cyc), 32'(exp_psel_cyc));
        chk({tag, "_pen_cyc"},  32'(pen_cyc),  32'(exp_pen_cyc));
        tick();
        chk({tag, "_rspv_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_out"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int setup_at[2];
        int nsetup;
        int nrsp;
        logic [2:0] psel_prev;

        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        prdata    = 8'h00;
        pready    = 1'b0;
        pslverr   = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        presetn = 1'b1;
        tick();
        chk("ready_after_rel", 32'(cmd_ready), 32'd1);

        xfer("wr20",  1'b1, 8'h20, 8'hA5, 1,  8'h77, 1'b0, 3'b100, 3, 2, 4,  8'h00, 1'b0);
        xfer("rd21",  1'b0, 8'h21, 8'h00, 0,  8'h3C, 1'b0, 3'b100, 2, 1, 3,  8'h3C, 1'b0);
        xfer("rd50",  1'b0, 8'h50, 8'h00, 0,  8'h11, 1'b0, 3'b000, 0, 0, 1,  8'h00, 1'b1);
        xfer("tmo",   1'b0, 8'h10, 8'h00, -1, 8'hFF, 1'b0, 3'b010, 9, 8, 10, 8'h00, 1'b1);
        xfer("rd22",  1'b0, 8'h22, 8'h00, 0,  8'h02, 1'b0, 3'b100, 2, 1, 3,  8'h02, 1'b0);
        xfer("slverr",1'b1, 8'h05, 8'h5A, 2,  8'h00, 1'b1, 3'b001, 4, 3, 5,  8'h00, 1'b1);

        // Back-to-back writes with cmd_valid held high and a zero-wait slave.
        nsetup    = 0;
        nrsp      = 0;
        psel_prev = 3'b000;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h20;
        cmd_wdata = 8'h11;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (psel != 3'b000 && !penable && psel_prev == 3'b000 && nsetup < 2) begin
                setup_at[nsetup] = cyc;
                chk("b2b_pwdata", 32'(pwdata), (nsetup == 0) ? 32'h11 : 32'h22);
                nsetup++;
                cmd_wdata = 8'h22;
                if (nsetup == 2) cmd_valid = 1'b0;
            end
            if (rsp_valid) nrsp++;
            pready    = penable;
            prdata    = 8'h00;
            psel_prev = psel;
        end
        pready = 1'b0;
        chk("b2b_setups", 32'(nsetup), 32'd2);
        if (nsetup == 2) chk("b2b_spacing", 32'(setup_at[1] - setup_at[0]), 32'd4);
        chk("b2b_rsps", 32'(nrsp), 32'd2);

        // Reset during ACCESS, held for two edges.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h20;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_in_access", 32'(penable), 32'd1);
        presetn = 1'b0;
        tick();
        chk_all_zero("mid_rst1");
        tick();
        chk_all_zero("mid_rst2");
        presetn = 1'b1;
        tick();
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        xfer("post_rst", 1'b0, 8'h01, 8'h00, 0, 8'hC3, 1'b0, 3'b001, 2, 1, 3, 8'hC3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
